// File: rtl/fft_pkg.sv
// Shared state encoding and size helpers for the in-place radix-2 DIT FFT scheduler.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fft_state_e;

    function automatic int fft_n(input int nba);
        return 2 ** nba;
    endfunction

    function automatic int fft_nbut(input int nba);
        return fft_n(nba) / 2;
    endfunction

    // Width of the stage counter; it must hold values 0..nba-1.
    function automatic int fft_sw(input int nba);
        return $clog2(nba);
    endfunction

endpackage

// File: rtl/fft_scheduler_if.sv
// Control and RAM/ROM address bundle between the FFT scheduler and its datapath.
interface fft_scheduler_if #(
    parameter int NBA = 4
);
    logic           i_start;
    logic           o_busy;
    logic           o_done;
    logic           o_rd_en;
    logic [NBA-1:0] o_rd_addr_x;
    logic [NBA-1:0] o_rd_addr_y;
    logic [NBA-2:0] o_tw_addr;
    logic           o_wr_en;
    logic [NBA-1:0] o_wr_addr_x;
    logic [NBA-1:0] o_wr_addr_y;

    modport master (
        input  i_start,
        output o_busy, o_done, o_rd_en, o_rd_addr_x, o_rd_addr_y, o_tw_addr,
        output o_wr_en, o_wr_addr_x, o_wr_addr_y
    );

    modport slave (
        output i_start,
        input  o_busy, o_done, o_rd_en, o_rd_addr_x, o_rd_addr_y, o_tw_addr,
        input  o_wr_en, o_wr_addr_x, o_wr_addr_y
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Combinational map from (stage, butterfly index) to operand addresses and twiddle index.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int NBA = 4
) (
    input  logic [fft_sw(NBA)-1:0] stage_i,
    input  logic [NBA-2:0]         k_i,
    output logic [NBA-1:0]         rd_addr_x_o,
    output logic [NBA-1:0]         rd_addr_y_o,
    output logic [NBA-2:0]         tw_addr_o
);

    logic [NBA-1:0] kExt;
    logic [NBA-1:0] half;
    logic [NBA-1:0] pos;
    logic [NBA-1:0] grp;
    logic [NBA-1:0] addrX;

    // pos < half <= 2**(NBA-1), so pos always fits the narrower twiddle width.
    always_comb begin
        kExt        = NBA'(k_i);
        half        = NBA'(1) << stage_i;
        pos         = kExt & (half - NBA'(1));
        grp         = kExt >> stage_i;
        addrX       = (grp << (int'(stage_i) + 1)) | pos;
        rd_addr_x_o = addrX;
        rd_addr_y_o = addrX + half;
        tw_addr_o   = (NBA-1)'(pos) << (NBA - 1 - int'(stage_i));
    end

endmodule

// File: rtl/fft_scheduler.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT with a one-cycle write delay.
module fft_scheduler
    import fft_pkg::*;
#(
    parameter int NBA = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    fft_scheduler_if.master bus
);

    localparam int SW   = fft_sw(NBA);
    localparam int NBUT = fft_nbut(NBA);
    localparam logic [NBA-2:0] K_LAST = (NBA-1)'(NBUT - 1);
    localparam logic [SW-1:0]  S_LAST = SW'(NBA - 1);

    fft_state_e     state_q, state_d;
    logic [SW-1:0]  stage_q, stage_d;
    logic [NBA-2:0] k_q, k_d;
    logic           wrEn_q;
    logic [NBA-1:0] wrAddrX_q, wrAddrY_q;

    logic           rdEn;
    logic [NBA-1:0] genX, genY;
    logic [NBA-2:0] genTw;

    fft_addr_gen #(.NBA(NBA)) addrGen (
        .stage_i    (stage_q),
        .k_i        (k_q),
        .rd_addr_x_o(genX),
        .rd_addr_y_o(genY),
        .tw_addr_o  (genTw)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = RUN;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = FLUSH;
                    k_d     = '0;
                end
            end
            // One idle slot lets the last write of a stage land before the next stage reads it.
            FLUSH: begin
                if (stage_q == S_LAST) begin
                    state_d = DONE;
                end else begin
                    stage_d = stage_q + 1'b1;
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
                stage_d = '0;
                k_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdEn            = (state_q == RUN);
    assign bus.o_rd_en     = rdEn;
    assign bus.o_rd_addr_x = rdEn ? genX  : '0;
    assign bus.o_rd_addr_y = rdEn ? genY  : '0;
    assign bus.o_tw_addr   = rdEn ? genTw : '0;
    assign bus.o_busy      = (state_q == RUN) || (state_q == FLUSH);
    assign bus.o_done      = (state_q == DONE);
    assign bus.o_wr_en     = wrEn_q;
    assign bus.o_wr_addr_x = wrAddrX_q;
    assign bus.o_wr_addr_y = wrAddrY_q;

    // Clearing the write-delay stage on reset drops any read that was in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            k_q       <= '0;
            wrEn_q    <= 1'b0;
            wrAddrX_q <= '0;
            wrAddrY_q <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            k_q       <= k_d;
            wrEn_q    <= rdEn;
            wrAddrX_q <= bus.o_rd_addr_x;
            wrAddrY_q <= bus.o_rd_addr_y;
        end
    end

endmodule

// File: tb/tb_fft_scheduler.sv
// Directed bench: NBA=3 timing/address tables and an NBA=4 butterfly scoreboard.
module tb_fft_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   vecCount  = 0;
    int   missCount = 0;

    int ramRe [16];
    int ramIm [16];
    int twRe  [8];
    int twIm  [8];
    int pAr, pAi, pBr, pBi, pTw;

    always #5 clk = ~clk;

    fft_scheduler_if #(.NBA(3)) bus3 ();
    fft_scheduler_if #(.NBA(4)) bus4 ();

    fft_scheduler #(.NBA(3)) dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3));
    fft_scheduler #(.NBA(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] out3();
        return {bus3.o_busy, bus3.o_done, bus3.o_rd_en, bus3.o_rd_addr_x, bus3.o_rd_addr_y,
                bus3.o_tw_addr, bus3.o_wr_en, bus3.o_wr_addr_x, bus3.o_wr_addr_y};
    endfunction

    function automatic logic [22:0] out4();
        return {bus4.o_busy, bus4.o_done, bus4.o_rd_en, bus4.o_rd_addr_x, bus4.o_rd_addr_y,
                bus4.o_tw_addr, bus4.o_wr_en, bus4.o_wr_addr_x, bus4.o_wr_addr_y};
    endfunction

    // Hand-derived NBA=3 read schedule: {rd_en, x, y, tw} for cycle c after a start at edge 0.
    function automatic logic [8:0] expRd3(input int c);
        int st;
        int j;
        logic [7:0] e;
        if (c < 1 || c > 15) return 9'd0;
        st = (c - 1) / 5;
        j  = (c - 1) % 5;
        if (j == 4) return 9'd0;
        case (st * 4 + j)
            0:       e = {3'd0, 3'd1, 2'd0};
            1:       e = {3'd2, 3'd3, 2'd0};
            2:       e = {3'd4, 3'd5, 2'd0};
            3:       e = {3'd6, 3'd7, 2'd0};
            4:       e = {3'd0, 3'd2, 2'd0};
            5:       e = {3'd1, 3'd3, 2'd2};
            6:       e = {3'd4, 3'd6, 2'd0};
            7:       e = {3'd5, 3'd7, 2'd2};
            8:       e = {3'd0, 3'd4, 2'd0};
            9:       e = {3'd1, 3'd5, 2'd1};
            10:      e = {3'd2, 3'd6, 2'd2};
            default: e = {3'd3, 3'd7, 2'd3};
        endcase
        return {1'b1, e};
    endfunction

    function automatic int rev4(input int v);
        logic [3:0] a;
        a = v[3:0];
        return int'({a[0], a[1], a[2], a[3]});
    endfunction

    // Datapath model for the NBA=4 instance: sync-read RAM, ROM twiddle, butterfly scaled by 1/2.
    always @(posedge clk) begin : scoreboard
        int tRe, tIm, xRe, xIm, yRe, yIm;
        #1;
        tRe = 0; tIm = 0; xRe = 0; xIm = 0; yRe = 0; yIm = 0;
        if (bus4.o_wr_en === 1'b1) begin
            tRe = (pBr * twRe[pTw] - pBi * twIm[pTw] + 8192) >>> 14;
            tIm = (pBr * twIm[pTw] + pBi * twRe[pTw] + 8192) >>> 14;
            xRe = (pAr + tRe + 1) >>> 1;
            xIm = (pAi + tIm + 1) >>> 1;
            yRe = (pAr - tRe + 1) >>> 1;
            yIm = (pAi - tIm + 1) >>> 1;
        end
        if (bus4.o_rd_en === 1'b1) begin
            pAr = ramRe[bus4.o_rd_addr_x];
            pAi = ramIm[bus4.o_rd_addr_x];
            pBr = ramRe[bus4.o_rd_addr_y];
            pBi = ramIm[bus4.o_rd_addr_y];
            pTw = int'(bus4.o_tw_addr);
        end
        if (bus4.o_wr_en === 1'b1) begin
            ramRe[bus4.o_wr_addr_x] = xRe;
            ramIm[bus4.o_wr_addr_x] = xIm;
            ramRe[bus4.o_wr_addr_y] = yRe;
            ramIm[bus4.o_wr_addr_y] = yIm;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus3.i_start = 1'b0;
        bus4.i_start = 1'b0;
        nextCycle();
        nextCycle();
        vecCount++;
        if (out3() !== 18'd0) begin
            missCount++;
            $display("[TB] FAIL reset_in3 got %h want 0", out3());
        end
        vecCount++;
        if (out4() !== 23'd0) begin
            missCount++;
            $display("[TB] FAIL reset_in4 got %h want 0", out4());
        end
        rst = 1'b0;
        nextCycle();
        vecCount++;
        if (out3() !== 18'd0) begin
            missCount++;
            $display("[TB] FAIL idle_after_reset3 got %h want 0", out3());
        end
        vecCount++;
        if (out4() !== 23'd0) begin
            missCount++;
            $display("[TB] FAIL idle_after_reset4 got %h want 0", out4());
        end
    endtask

    task automatic test_timing(input string label);
        logic [2:0] expv;
        logic [2:0] got;
        logic [8:0] r;
        bus3.i_start = 1'b1;
        nextCycle();
        bus3.i_start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            r    = expRd3(c);
            expv = {(c >= 1 && c <= 15), r[8], (c == 16)};
            got  = {bus3.o_busy, bus3.o_rd_en, bus3.o_done};
            vecCount++;
            if (got !== expv) begin
                missCount++;
                $display("[TB] FAIL %s cycle %0d busy/rd/done got %b want %b", label, c, got, expv);
            end
            nextCycle();
        end
    endtask

    task automatic test_addresses();
        logic [8:0] got;
        bus3.i_start = 1'b1;
        nextCycle();
        bus3.i_start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            got = {bus3.o_rd_en, bus3.o_rd_addr_x, bus3.o_rd_addr_y, bus3.o_tw_addr};
            vecCount++;
            if (got !== expRd3(c)) begin
                missCount++;
                $display("[TB] FAIL rd_addr cycle %0d en/x/y/tw got %h want %h", c, got, expRd3(c));
            end
            nextCycle();
        end
        nextCycle();
        nextCycle();
    endtask

    task automatic test_write_delay();
        logic [8:0] prev;
        logic [6:0] got;
        logic [6:0] expv;
        bus3.i_start = 1'b1;
        nextCycle();
        bus3.i_start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            prev = expRd3(c - 1);
            expv = {prev[8], prev[7:5], prev[4:2]};
            got  = {bus3.o_wr_en, bus3.o_wr_addr_x, bus3.o_wr_addr_y};
            vecCount++;
            if (got !== expv) begin
                missCount++;
                $display("[TB] FAIL wr_delay cycle %0d en/x/y got %h want %h", c, got, expv);
            end
            nextCycle();
        end
    endtask

    task automatic test_start_held();
        int busyCnt = 0;
        int doneCnt = 0;
        int rdCnt   = 0;
        bus3.i_start = 1'b1;
        nextCycle();
        for (int c = 1; c <= 22; c++) begin
            if (c == 17) bus3.i_start = 1'b0;
            if (bus3.o_busy)  busyCnt++;
            if (bus3.o_done)  doneCnt++;
            if (bus3.o_rd_en) rdCnt++;
            nextCycle();
        end
        vecCount++;
        if (doneCnt != 1) begin
            missCount++;
            $display("[TB] FAIL held_start done_pulses got %0d want 1", doneCnt);
        end
        vecCount++;
        if (busyCnt != 15) begin
            missCount++;
            $display("[TB] FAIL held_start busy_cycles got %0d want 15", busyCnt);
        end
        vecCount++;
        if (rdCnt != 12) begin
            missCount++;
            $display("[TB] FAIL held_start reads got %0d want 12", rdCnt);
        end
        vecCount++;
        if (out3() !== 18'd0) begin
            missCount++;
            $display("[TB] FAIL held_start final_idle got %h want 0", out3());
        end
    endtask

    task automatic test_midrun_reset();
        logic [8:0] got;
        logic [2:0] flags;
        bus3.i_start = 1'b1;
        nextCycle();
        bus3.i_start = 1'b0;
        for (int c = 1; c < 7; c++) nextCycle();
        got = {bus3.o_rd_en, bus3.o_rd_addr_x, bus3.o_rd_addr_y, bus3.o_tw_addr};
        vecCount++;
        if (got !== expRd3(7)) begin
            missCount++;
            $display("[TB] FAIL pre_reset cycle 7 got %h want %h", got, expRd3(7));
        end
        rst = 1'b1;
        #1;
        vecCount++;
        if (out3() !== 18'd0) begin
            missCount++;
            $display("[TB] FAIL async_reset outputs got %h want 0", out3());
        end
        nextCycle();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            flags = {bus3.o_wr_en, bus3.o_busy, bus3.o_rd_en};
            vecCount++;
            if (flags !== 3'b000) begin
                missCount++;
                $display("[TB] FAIL post_reset cycle %0d wr/busy/rd got %b want 000", c, flags);
            end
            nextCycle();
        end
        test_timing("after_reset");
    endtask

    task automatic test_fft_delta(input int n0, input int tol);
        int doneCycle = 0;
        int expRe, expIm, dRe, dIm;
        real ang;
        for (int i = 0; i < 8; i++) begin
            ang     = 6.283185307179586 * real'(i) / 16.0;
            twRe[i] = $rtoi($floor(16384.0 * $cos(ang) + 0.5));
            twIm[i] = -$rtoi($floor(16384.0 * $sin(ang) + 0.5));
        end
        for (int i = 0; i < 16; i++) begin
            ramRe[i] = 0;
            ramIm[i] = 0;
        end
        ramRe[rev4(n0)] = 16384;
        bus4.i_start = 1'b1;
        nextCycle();
        bus4.i_start = 1'b0;
        for (int c = 1; c <= 200 && doneCycle == 0; c++) begin
            if (bus4.o_done) doneCycle = c;
            else nextCycle();
        end
        vecCount++;
        if (doneCycle != 37) begin
            missCount++;
            $display("[TB] FAIL fft%0d done_cycle got %0d want 37", n0, doneCycle);
        end
        nextCycle();
        for (int k = 0; k < 16; k++) begin
            ang   = 6.283185307179586 * real'(k * n0) / 16.0;
            expRe = $rtoi($floor(1024.0 * $cos(ang) + 0.5));
            expIm = -$rtoi($floor(1024.0 * $sin(ang) + 0.5));
            dRe   = ramRe[k] - expRe;
            dIm   = ramIm[k] - expIm;
            vecCount++;
            if (dRe > tol || dRe < -tol || dIm > tol || dIm < -tol) begin
                missCount++;
                $display("[TB] FAIL fft%0d bin %0d got (%0d,%0d) want (%0d,%0d)",
                         n0, k, ramRe[k], ramIm[k], expRe, expIm);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        bus3.i_start = 1'b0;
        bus4.i_start = 1'b0;
        test_reset();
        test_timing("timing");
        test_addresses();
        test_write_delay();
        test_start_held();
        test_midrun_reset();
        test_fft_delta(0, 1);
        test_fft_delta(1, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/fft_scheduler.md
FFT_SCHEDULER -- requirements
Module: fft_scheduler

Interface
REQ-001 The block SHALL have parameter NBA, default 'd4, meaning log2 of FFT points N; N = 2**NBA, NBA >= 2.
REQ-002 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 i_clk  input  1  clock; all state changes on rising edge.
REQ-004 i_rst  input  1  asynchronous active-high reset.
REQ-005 i_start  input  1  request one complete in-place radix-2 DIT FFT run.
REQ-006 o_busy  output  1  high from the first RUN cycle through the last FLUSH cycle.
REQ-007 o_done  output  1  one-cycle pulse after the final write.
REQ-008 o_rd_en  output  1  read strobe to the dual-port data RAM (synchronous read, 1-cycle latency).
REQ-009 o_rd_addr_x, o_rd_addr_y  output  NBA each  butterfly operand addresses.
REQ-010 o_tw_addr  output  NBA-1  twiddle ROM index, issued with the read strobe (ROM has 1-cycle latency).
REQ-011 o_wr_en  output  1  write strobe for the butterfly results.
REQ-012 o_wr_addr_x, o_wr_addr_y  output  NBA each  result addresses.

Function
REQ-013 The FSM SHALL use states IDLE, RUN, FLUSH and DONE.
REQ-014 IDLE->RUN on i_start=1; i_start SHALL be ignored in RUN, FLUSH and DONE.
REQ-015 In RUN, the block SHALL issue one butterfly per cycle: o_rd_en=1, with stage s in 0..NBA-1 and butterfly index k in 0..N/2-1.
REQ-016 Address rule: h=2**s, pos=k mod h, grp=k div h; rd_addr_x=grp*2h+pos; rd_addr_y=rd_addr_x+h; tw_addr=pos*2**(NBA-1-s).
REQ-017 k SHALL increment each RUN cycle; at k=N/2-1 the state SHALL go RUN->FLUSH, and k SHALL wrap to 0.
REQ-018 FLUSH SHALL last exactly one cycle with o_rd_en=0. It prevents a read-after-write hazard across the stage boundary.
REQ-019 From FLUSH, if s<NBA-1, the block SHALL increment s and go to RUN; if s=NBA-1, it SHALL go to DONE.
REQ-020 DONE SHALL assert o_done for one cycle, then go to IDLE with s=0 and k=0.
REQ-021 Write timing: o_wr_en, o_wr_addr_x and o_wr_addr_y SHALL equal o_rd_en, o_rd_addr_x and o_rd_addr_y delayed by exactly one cycle. The butterfly is combinational between RAM output and RAM write port.
REQ-022 Run length: i_start sampled at edge 0 -> first o_rd_en at cycle 1. Total length SHALL be NBA*(N/2+1) cycles of o_busy, then one o_done cycle.
REQ-023 Outside RUN, o_rd_addr_*, o_tw_addr and o_rd_en SHALL be 0. Outside a write cycle, o_wr_addr_* SHALL be 0.
REQ-024 Input data SHALL be in bit-reversed order in RAM; output is in natural order. Data reordering is outside this block.
REQ-025 i_start asserted in the same cycle as o_done SHALL be ignored. A new run SHALL start only from IDLE.

Reset
REQ-026 i_rst SHALL, asynchronously and at any time including mid-run, force IDLE, s=0, k=0, and all outputs to 0.
REQ-027 A read in flight at reset SHALL NOT produce a write after reset deasserts.

Structure
REQ-028 The shared package fft_pkg SHALL hold the state encoding (IDLE, RUN, FLUSH, DONE) and the localparam helpers N=2**NBA and NBUT=N/2.
REQ-029 A combinational sub-module fft_addr_gen SHALL map (s, k) to rd_addr_x, rd_addr_y and tw_addr. The FSM, counters and write-delay register SHALL stay in fft_scheduler.

Verification
REQ-030 NBA=3, i_start pulse at cycle 0 -> o_busy for cycles 1..15, o_rd_en at cycles 1-4, 6-9 and 11-14, FLUSH at cycles 5, 10 and 15, o_done at cycle 16.
REQ-031 NBA=3, stage 1 -> (x,y,tw) sequence (0,2,0), (1,3,2), (4,6,0), (5,7,2). Stage 2 -> (0,4,0), (1,5,1), (2,6,2), (3,7,3).
REQ-032 NBA=3, every o_wr_en cycle -> o_wr_addr_* equals the previous cycle's o_rd_addr_*. There is no o_wr_en/o_rd_en to the same address at a stage boundary.
REQ-033 i_start held high during a run and in the o_done cycle -> exactly one run occurs and the FSM returns to IDLE.
REQ-034 i_rst pulsed mid-stage 1 -> all outputs are 0 immediately and no o_wr_en follows. A new i_start then reproduces the REQ-030 timing.
REQ-035 NBA=4 with a scoreboard: butterfly model on an impulse input -> the 16-point result equals the reference FFT scaled by 1/16 within +/-1 LSB.
